// File: rtl/alu_issue_if.sv
// alu_issue_if: request/response handshake bundle between decode, alu_issue and writeback.
interface alu_issue_if #(
  parameter int XLEN = 32,
  parameter int SEQW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_aluop;
  logic [2:0]      in_funct3;
  logic            in_funct7b5;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            out_err;
  logic [SEQW-1:0] out_seq;
  modport master (
    output in_valid, in_aluop, in_funct3, in_funct7b5, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_err, out_seq
  );
  modport slave (
    input  in_valid, in_aluop, in_funct3, in_funct7b5, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_err, out_seq
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/retire front end driving the combinational rv32i alu.
module alu_issue #(
  parameter int XLEN = 32,
  parameter int SEQW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_if.slave      bus,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] alu_i1_o,
  output logic [XLEN-1:0] alu_i2_o,
  input  logic [XLEN-1:0] alu_out_i,
  input  logic            alu_zero_i
);
  logic [3:0]      dec_op, op_q, op_d;
  logic            dec_err, r_ok, adv, accept;
  logic            s1_valid_q, s1_valid_d, s1_err_q, s1_err_d;
  logic            out_valid_q, out_valid_d, zero_q, zero_d, err_q, err_d;
  logic [SEQW-1:0] seq_q, seq_d, s1_seq_q, s1_seq_d, out_seq_q, out_seq_d;
  logic [XLEN-1:0] i1_q, i1_d, i2_q, i2_d, res_q, res_d;

  assign adv          = s1_valid_q && (!out_valid_q || bus.out_ready);
  assign bus.in_ready = !s1_valid_q || adv;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    r_ok    = (bus.in_funct3 inside {3'b111, 3'b110, 3'b000}) || (bus.in_funct3 == 3'b010 && !bus.in_funct7b5);
    dec_err = bus.in_aluop == 2'b11 || (bus.in_aluop == 2'b10 && !r_ok);
    dec_op  = dec_err ? 4'd0 : bus.in_aluop == 2'b00 ? 4'd2 : bus.in_aluop == 2'b01 ? 4'd6 :
              bus.in_funct3 == 3'b111 ? 4'd0 : bus.in_funct3 == 3'b110 ? 4'd1 :
              bus.in_funct3 == 3'b010 ? 4'd7 : bus.in_funct7b5 ? 4'd6 : 4'd2;
  end

  // ALU operand registers only load on accept so the alu inputs stay quiet when idle
  always_comb begin
    s1_valid_d  = accept || (s1_valid_q && !adv);
    op_d        = accept ? dec_op : op_q;
    i1_d        = accept ? bus.in_a : i1_q;
    i2_d        = accept ? bus.in_b : i2_q;
    s1_err_d    = accept ? dec_err : s1_err_q;
    s1_seq_d    = accept ? seq_q : s1_seq_q;
    seq_d       = accept ? seq_q + 1'b1 : seq_q;
    out_valid_d = adv || (out_valid_q && !bus.out_ready);
    res_d       = adv ? (s1_err_q ? '0 : alu_out_i) : res_q;
    zero_d      = adv ? (s1_err_q || alu_zero_i) : zero_q;
    err_d       = adv ? s1_err_q : err_q;
    out_seq_d   = adv ? s1_seq_q : out_seq_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      op_q        <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
      s1_err_q    <= 1'b0;
      s1_seq_q    <= '0;
      seq_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      out_seq_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      op_q        <= op_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      s1_err_q    <= s1_err_d;
      s1_seq_q    <= s1_seq_d;
      seq_q       <= seq_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      out_seq_q   <= out_seq_d;
    end
  end

  assign alu_op_o       = op_q;
  assign alu_i1_o       = i1_q;
  assign alu_i2_o       = i2_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = res_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_err    = err_q;
  assign bus.out_seq    = out_seq_q;
endmodule
